l2_burst_adaptor: RTL and testbench
===================================

Name: l2_burst_adaptor

Overview:
- Sits directly downstream of the L2 cache controller/datapath, between the L2 line port and the burst-mode physical memory.
- Converts one 256-bit line read or write request into four 64-bit memory beats, then returns a single-cycle line-level response.
- The upstream side behaves as an ideal line-wide memory: request held until response.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, memory beat width in bits.
- ADDR_WIDTH, 32, byte address width.
- Derived: BEATS = LINE_WIDTH/BURST_WIDTH = 4; OFFSET_BITS = log2(LINE_WIDTH/8) = 5.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- line_addr_i  in  ADDR_WIDTH  line address from L2 (CPU or eviction address, already muxed).
- line_wdata_i  in  LINE_WIDTH  line to write back.
- line_read_i  in  1  line read request; held until line_resp_o.
- line_write_i  in  1  line write request; held until line_resp_o.
- line_rdata_o  out  LINE_WIDTH  assembled read line.
- line_resp_o  out  1  one-cycle completion pulse.
- mem_addr_o  out  ADDR_WIDTH  line-aligned burst address.
- mem_wdata_o  out  BURST_WIDTH  current write beat.
- mem_rdata_i  in  BURST_WIDTH  current read beat.
- mem_read_o  out  1  burst read request.
- mem_write_o  out  1  burst write request.
- mem_resp_i  in  1  beat accepted/valid this cycle.

Behaviour:
- Reset values: all outputs 0; line buffer, write buffer, address register and beat counter cleared to 0; state IDLE.
- States: IDLE, READ, WRITE, DONE.

IDLE:
- On line_write_i=1: latch line_wdata_i and line_addr_i, clear the counter, go to WRITE.
- Else on line_read_i=1: latch the address, clear the counter, go to READ.
- If both requests are high, write wins. Read is not serviced; it is re-sampled after DONE.
- No memory outputs are asserted.

READ:
- mem_read_o=1 for the whole state.
- Each cycle with mem_resp_i=1: store mem_rdata_i into line buffer bits [cnt*64 +: 64], then cnt++.
- Beat 0 is the lowest 64 bits. Beats need not be consecutive; cycles with mem_resp_i=0 change nothing.
- When the beat at cnt=3 is accepted, go to DONE.

WRITE:
- mem_write_o=1; mem_wdata_o = write buffer [cnt*64 +: 64].
- Each cycle with mem_resp_i=1 advances cnt.
- When the beat at cnt=3 is accepted, go to DONE.

DONE:
- line_resp_o=1 for exactly one cycle, then go to IDLE.
- line_rdata_o is driven continuously from the line buffer. It stays stable from DONE until the next read's first beat, so the L2 may load it in the resp cycle or later.
- A write does not modify the line buffer.

Address and counter:
- mem_addr_o = latched address with bits [4:0] forced to 0. Stable for the entire READ/WRITE.
- mem_addr_o is 0 in IDLE/DONE.
- cnt is 2 bits and never wraps inside a transaction; it is cleared on entry to READ/WRITE.

Other rules:
- mem_resp_i outside READ/WRITE is ignored.
- Request inputs changing mid-transaction are ignored, because data and address are latched on acceptance.

Latency:
- Request sampled in IDLE at cycle 0; mem_read_o/mem_write_o high from cycle 1.
- With mem_resp_i high on cycles 1-4, line_resp_o is high in cycle 5. Minimum latency is 5 cycles plus memory stalls.

Back-to-back:
- A request still high in IDLE after DONE starts a new transaction. The L2 controller drops its request on line_resp_o, so no spurious repeat occurs.

Reset mid-transaction:
- Abort immediately to IDLE with all outputs 0 in the next cycle. No line_resp_o is issued.

Decomposition:
- Shared package l2_pkg: LINE_WIDTH, BURST_WIDTH, ADDR_WIDTH, BEATS, OFFSET_BITS constants; adaptor state enum type; line_t and beat_t typedefs.
- No sub-module. Counter, buffers and FSM stay in a single module; beat select is an indexed part-select.

Test Plan:
- Read, no stalls: line_read_i=1, addr 0x0000_1234; mem_resp_i high cycles 1-4 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  -> mem_addr_o=0x0000_1220 throughout; line_resp_o high only in cycle 5; line_rdata_o = {0x44..,0x33..,0x22..,0x11..}.
- Write with stalls: line_write_i=1, line_wdata_i=pattern with beat k = 0xA0+k replicated; mem_resp_i pattern 1,0,0,1,1,0,1.
  -> mem_wdata_o advances only after each resp; mem_write_o drops after the 4th accepted beat; one line_resp_o pulse.
- Simultaneous line_read_i and line_write_i in IDLE -> WRITE entered, mem_read_o never asserted during it; after DONE, with read still high, the READ transaction starts.
- Reset asserted after 2 read beats -> next cycle all outputs 0, state IDLE, no line_resp_o. A fresh read then completes normally with correct data.
- Back-to-back: write at 0x100, then immediately read at 0x200 -> mem_addr_o 0x100 then 0x200. Line data from the first read is unchanged by the intervening write until the read's first beat.
- Spurious mem_resp_i=1 in IDLE for 3 cycles -> no state change, cnt stays 0, no outputs asserted.

Source files
------------

// File: rtl/l2_pkg.sv
// l2_pkg
// Shared constants and types for the L2 side of the memory hierarchy.
//   LINE_WIDTH  : cache line width in bits
//   BURST_WIDTH : width of one burst beat on the physical memory bus
//   ADDR_WIDTH  : byte address width
//   BEATS       : beats per line
//   OFFSET_BITS : byte-offset bits inside one line
// Also provides the adaptor state enum, the line/beat/address types and a
// helper that aligns a byte address down to its line boundary.
package l2_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_WIDTH   = $clog2(BEATS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } adaptor_state_e;

  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [BURST_WIDTH-1:0] beat_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [CNT_WIDTH-1:0]   cnt_t;

  // Index of the final beat of a line; reaching it ends the burst.
  localparam cnt_t LAST_BEAT = cnt_t'(BEATS - 1);

  // Memory always sees whole-line bursts, so the byte offset is dropped.
  function automatic addr_t line_align(input addr_t addr);
    return {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_burst_adaptor.sv
// l2_burst_adaptor
// Turns one line-wide read or write from the L2 controller into a four-beat
// burst on the physical memory port, then returns a single-cycle line
// response. Upstream holds its request until line_resp_o.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   line_addr_i     : line byte address from L2
//   line_wdata_i    : line to write back
//   line_read_i     : line read request (held until line_resp_o)
//   line_write_i    : line write request (held until line_resp_o)
//   line_rdata_o    : assembled read line, stable from response until the
//                     next read's first beat
//   line_resp_o     : one-cycle completion pulse
//   mem_addr_o      : line-aligned burst address, 0 when idle
//   mem_wdata_o     : current write beat, 0 outside a write
//   mem_rdata_i     : current read beat
//   mem_read_o      : burst read request
//   mem_write_o     : burst write request
//   mem_resp_i      : beat accepted / valid this cycle
module l2_burst_adaptor
  import l2_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  addr_t line_addr_i,
  input  line_t line_wdata_i,
  input  logic  line_read_i,
  input  logic  line_write_i,
  output line_t line_rdata_o,
  output logic  line_resp_o,
  output addr_t mem_addr_o,
  output beat_t mem_wdata_o,
  input  beat_t mem_rdata_i,
  output logic  mem_read_o,
  output logic  mem_write_o,
  input  logic  mem_resp_i
);

  adaptor_state_e state;
  cnt_t           cnt;
  line_t          line_buf;
  line_t          wr_buf;

  // The read line is exposed straight from the buffer; it only changes as
  // read beats land, so it stays valid after the response pulse.
  assign line_rdata_o = line_buf;

  // Write beat select. Gated so nothing toggles on the bus outside WRITE.
  always_comb begin
    mem_wdata_o = '0;
    if (state == ST_WRITE) begin
      mem_wdata_o = wr_buf[int'(cnt)*BURST_WIDTH +: BURST_WIDTH];
    end
  end

  // Main FSM. mem_addr_o doubles as the latched address register; it is
  // loaded on acceptance and cleared as the burst ends, so it reads 0 in
  // IDLE and DONE. Write wins when both requests arrive together; the read
  // stays pending upstream and is picked up once we are back in IDLE.
  // The counter is cleared on the last beat so it always rests at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      line_buf    <= '0;
      wr_buf      <= '0;
      mem_addr_o  <= '0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      line_resp_o <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          line_resp_o <= 1'b0;
          if (line_write_i) begin
            wr_buf      <= line_wdata_i;
            mem_addr_o  <= line_align(line_addr_i);
            cnt         <= '0;
            mem_write_o <= 1'b1;
            state       <= ST_WRITE;
          end else if (line_read_i) begin
            mem_addr_o  <= line_align(line_addr_i);
            cnt         <= '0;
            mem_read_o  <= 1'b1;
            state       <= ST_READ;
          end
        end

        ST_READ: begin
          if (mem_resp_i) begin
            line_buf[int'(cnt)*BURST_WIDTH +: BURST_WIDTH] <= mem_rdata_i;
            if (cnt == LAST_BEAT) begin
              cnt         <= '0;
              mem_read_o  <= 1'b0;
              mem_addr_o  <= '0;
              line_resp_o <= 1'b1;
              state       <= ST_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_WRITE: begin
          if (mem_resp_i) begin
            if (cnt == LAST_BEAT) begin
              cnt         <= '0;
              mem_write_o <= 1'b0;
              mem_addr_o  <= '0;
              line_resp_o <= 1'b1;
              state       <= ST_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_DONE: begin
          line_resp_o <= 1'b0;
          state       <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_burst_adaptor.sv
// tb_l2_burst_adaptor
// Self-checking bench for l2_burst_adaptor. A line-level reference model
// (the last fully read line plus the beats received so far) predicts every
// DUT output cycle by cycle while the bench plays the memory, with
// randomized data, addresses and stall patterns.
module tb_l2_burst_adaptor;
  import l2_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  addr_t line_addr_i;
  line_t line_wdata_i;
  logic  line_read_i;
  logic  line_write_i;
  line_t line_rdata_o;
  logic  line_resp_o;
  addr_t mem_addr_o;
  beat_t mem_wdata_o;
  beat_t mem_rdata_i;
  logic  mem_read_o;
  logic  mem_write_o;
  logic  mem_resp_i;

  int    n_checks = 0;
  int    n_fail   = 0;
  line_t model_line;

  always #5 clk = ~clk;

  l2_burst_adaptor dut (
    .clk          (clk),
    .reset        (reset),
    .line_addr_i  (line_addr_i),
    .line_wdata_i (line_wdata_i),
    .line_read_i  (line_read_i),
    .line_write_i (line_write_i),
    .line_rdata_o (line_rdata_o),
    .line_resp_o  (line_resp_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_resp_i   (mem_resp_i)
  );

  function automatic line_t rand_line();
    line_t l;
    for (int w = 0; w < LINE_WIDTH / 32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one complete transaction and checks every cycle of it. The memory
  // accepts a beat whenever bit (cycle % 32) of pat is set. The serviced
  // request is dropped on the response, the other one is left as driven.
  task automatic drive_txn(input logic rd, input logic wr, input addr_t addr,
                           input line_t wdata, input logic [31:0] pat,
                           input string tag);
    beat_t beats[BEATS];
    line_t exp_line;
    addr_t exp_addr;
    int    k;
    int    cyc;
    for (int j = 0; j < BEATS; j++) beats[j] = {$urandom, $urandom};
    exp_addr     = addr & ~addr_t'(LINE_WIDTH / 8 - 1);
    line_addr_i  = addr;
    line_wdata_i = wdata;
    line_read_i  = rd;
    line_write_i = wr;
    mem_resp_i   = 1'b0;
    tick();
    // Request is latched now; scrambling the inputs must have no effect.
    line_addr_i  = $urandom;
    line_wdata_i = rand_line();
    k   = 0;
    cyc = 0;
    while (k < BEATS) begin
      if (cyc > 200) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s timeout: got %0d beats, expected %0d", tag, k, BEATS);
        break;
      end
      exp_line = model_line;
      if (!wr) for (int j = 0; j < k; j++) exp_line[j*BURST_WIDTH +: BURST_WIDTH] = beats[j];
      n_checks++;
      if ({mem_read_o, mem_write_o, line_resp_o} !== {!wr, wr, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL %s ctl beat%0d: got %b, expected %b", tag, k,
                 {mem_read_o, mem_write_o, line_resp_o}, {!wr, wr, 1'b0});
      end
      n_checks++;
      if (mem_addr_o !== exp_addr) begin
        n_fail++;
        $display("[TB] FAIL %s addr: got %h, expected %h", tag, mem_addr_o, exp_addr);
      end
      n_checks++;
      if (mem_wdata_o !== (wr ? wdata[k*BURST_WIDTH +: BURST_WIDTH] : beat_t'(0))) begin
        n_fail++;
        $display("[TB] FAIL %s wdata beat%0d: got %h, expected %h", tag, k, mem_wdata_o,
                 wr ? wdata[k*BURST_WIDTH +: BURST_WIDTH] : beat_t'(0));
      end
      n_checks++;
      if (line_rdata_o !== exp_line) begin
        n_fail++;
        $display("[TB] FAIL %s rdata beat%0d: got %h, expected %h", tag, k, line_rdata_o, exp_line);
      end
      mem_resp_i  = pat[cyc % 32];
      mem_rdata_i = beats[k];
      tick();
      if (mem_resp_i) k++;
      cyc++;
    end
    // Response cycle: a stray beat strobe here must be ignored.
    mem_resp_i  = 1'($urandom);
    mem_rdata_i = {$urandom, $urandom};
    if (!wr) for (int j = 0; j < BEATS; j++) model_line[j*BURST_WIDTH +: BURST_WIDTH] = beats[j];
    n_checks++;
    if ({mem_read_o, mem_write_o, line_resp_o, mem_addr_o} !== {3'b001, addr_t'(0)}) begin
      n_fail++;
      $display("[TB] FAIL %s done: got ctl %b addr %h, expected ctl 001 addr 0", tag,
               {mem_read_o, mem_write_o, line_resp_o}, mem_addr_o);
    end
    n_checks++;
    if (line_rdata_o !== model_line) begin
      n_fail++;
      $display("[TB] FAIL %s line: got %h, expected %h", tag, line_rdata_o, model_line);
    end
    if (wr) line_write_i = 1'b0;
    else    line_read_i  = 1'b0;
    tick();
    mem_resp_i = 1'b0;
    n_checks++;
    if ({mem_read_o, mem_write_o, line_resp_o, mem_addr_o} !== {3'b000, addr_t'(0)}) begin
      n_fail++;
      $display("[TB] FAIL %s idle: got ctl %b addr %h, expected ctl 000 addr 0", tag,
               {mem_read_o, mem_write_o, line_resp_o}, mem_addr_o);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    line_addr_i  = '0;
    line_wdata_i = '0;
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    mem_rdata_i  = '0;
    mem_resp_i   = 1'b0;
    model_line   = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({mem_read_o, mem_write_o, line_resp_o, mem_addr_o, mem_wdata_o, line_rdata_o} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset: got ctl %b addr %h wdata %h line %h, expected all 0",
               {mem_read_o, mem_write_o, line_resp_o}, mem_addr_o, mem_wdata_o, line_rdata_o);
    end
  endtask

  // Fixed beats 0x11.., 0x22.., 0x33.., 0x44.. with no stalls.
  task automatic test_read_no_stall();
    beat_t b;
    addr_t exp_addr;
    exp_addr     = 32'h0000_1220;
    line_addr_i  = 32'h0000_1234;
    line_read_i  = 1'b1;
    mem_resp_i   = 1'b0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      b = {8{8'(8'h11 * c)}};
      n_checks++;
      if ({mem_read_o, line_resp_o, mem_addr_o} !== {2'b10, exp_addr}) begin
        n_fail++;
        $display("[TB] FAIL read cycle%0d: got rd/resp %b addr %h, expected 10 %h", c,
                 {mem_read_o, line_resp_o}, mem_addr_o, exp_addr);
      end
      mem_resp_i  = 1'b1;
      mem_rdata_i = b;
      tick();
    end
    mem_resp_i = 1'b0;
    model_line = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    n_checks++;
    if ({mem_read_o, line_resp_o} !== 2'b01 || line_rdata_o !== model_line) begin
      n_fail++;
      $display("[TB] FAIL read cycle5: got rd/resp %b line %h, expected 01 %h",
               {mem_read_o, line_resp_o}, line_rdata_o, model_line);
    end
    line_read_i = 1'b0;
    tick();
    n_checks++;
    if (line_resp_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read cycle6 resp: got %b, expected 0", line_resp_o);
    end
  endtask

  task automatic test_write_stalls();
    line_t l;
    for (int k = 0; k < BEATS; k++) l[k*BURST_WIDTH +: BURST_WIDTH] = {8{8'(8'hA0 + k)}};
    drive_txn(1'b0, 1'b1, 32'h0000_4000, l, 32'h0000_0059, "write_stall");
  endtask

  task automatic test_simultaneous();
    line_read_i = 1'b1;
    drive_txn(1'b1, 1'b1, 32'h0000_0840, rand_line(), $urandom | 32'h1, "simul_wr");
    drive_txn(1'b1, 1'b0, 32'h0000_0840, '0, $urandom | 32'h1, "simul_rd");
  endtask

  task automatic test_reset_mid_read();
    line_addr_i = 32'h0000_3000;
    line_read_i = 1'b1;
    tick();
    repeat (2) begin
      mem_resp_i  = 1'b1;
      mem_rdata_i = {$urandom, $urandom};
      tick();
    end
    mem_resp_i = 1'b0;
    reset      = 1'b1;
    tick();
    reset       = 1'b0;
    line_read_i = 1'b0;
    model_line  = '0;
    n_checks++;
    if ({mem_read_o, mem_write_o, line_resp_o, mem_addr_o, mem_wdata_o, line_rdata_o} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset: got ctl %b addr %h line %h, expected all 0",
               {mem_read_o, mem_write_o, line_resp_o}, mem_addr_o, line_rdata_o);
    end
    repeat (3) begin
      tick();
      n_checks++;
      if ({mem_read_o, line_resp_o} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL midreset idle: got rd/resp %b, expected 00", {mem_read_o, line_resp_o});
      end
    end
    drive_txn(1'b1, 1'b0, 32'h0000_3008, '0, $urandom | 32'h1, "fresh_rd");
  endtask

  task automatic test_back_to_back();
    drive_txn(1'b1, 1'b0, 32'h0000_0200, '0, 32'hFFFF_FFFF, "b2b_rd0");
    drive_txn(1'b0, 1'b1, 32'h0000_0100, rand_line(), 32'hFFFF_FFFF, "b2b_wr");
    drive_txn(1'b1, 1'b0, 32'h0000_0200, '0, 32'hFFFF_FFFF, "b2b_rd1");
  endtask

  task automatic test_spurious_resp();
    mem_resp_i = 1'b1;
    repeat (3) begin
      mem_rdata_i = {$urandom, $urandom};
      tick();
      n_checks++;
      if ({mem_read_o, mem_write_o, line_resp_o, mem_addr_o, mem_wdata_o} !== '0 ||
          line_rdata_o !== model_line) begin
        n_fail++;
        $display("[TB] FAIL spurious: got ctl %b addr %h line %h, expected 000 0 %h",
                 {mem_read_o, mem_write_o, line_resp_o}, mem_addr_o, line_rdata_o, model_line);
      end
    end
    mem_resp_i = 1'b0;
    drive_txn(1'b0, 1'b1, 32'h0000_0500, rand_line(), 32'hFFFF_FFFF, "post_spur");
  endtask

  task automatic test_random();
    logic w;
    for (int t = 0; t < 20; t++) begin
      w = 1'($urandom);
      drive_txn(!w, w, $urandom, rand_line(), $urandom | 32'h1, w ? "rand_wr" : "rand_rd");
    end
  endtask

  initial begin
    test_reset();
    test_read_no_stall();
    test_write_stalls();
    test_simultaneous();
    test_reset_mid_read();
    test_back_to_back();
    test_spurious_resp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
